// File: rtl/acc_cpu_controller.sv
// acc_cpu_controller
//   Fetch/decode/execute sequencer for the 16-bit accumulator CPU. It owns
//   PC, IR, MBR and AC. It drives a synchronous single-port RAM and a
//   combinational ALU.
//
// Ports
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   start        : leave IDLE, load PC with START_ADDR and begin fetching
//   mem_addr     : registered RAM word address
//   mem_cs/we/oe : RAM chip select / write enable / output enable
//   mem_wdata    : RAM write data (the top level tristates the bus with !oe)
//   mem_rdata    : RAM read data, valid one cycle after the address is
//                  registered with cs=1, oe=1
//   alu_a/alu_b  : registered ALU operands
//   alu_sel      : 01 add, 10 sub, 00 idle
//   alu_out      : combinational ALU result
//   pc, ac, ir   : architectural state, for debug
//   busy         : high in every state except IDLE and HALTED
//   halted       : high in HALTED
//   illegal_op   : sticky, set when an undefined opcode is executed
//
// Optional build macro ACC_CPU_PERF_EN adds two saturating 32-bit counters:
//   cycle_cnt    : number of busy cycles
//   instr_cnt    : number of completed instructions (HALT included)
module acc_cpu_controller #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned START_ADDR = 'h100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [1:0]            alu_sel,
  input  logic [DATA_WIDTH-1:0] alu_out,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ac,
  output logic [DATA_WIDTH-1:0] ir,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal_op
`ifdef ACC_CPU_PERF_EN
  ,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_F1,
    S_F2,
    S_F3,
    S_DEC,
    S_E1,
    S_E2,
    S_E3,
    S_E4,
    S_E5,
    S_HALTED
  } state_e;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUBT  = 4'h4,
    OP_HALT  = 4'h7,
    OP_SKIP  = 4'h8,
    OP_JUMP  = 4'h9,
    OP_CLEAR = 4'hA
  } opcode_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] mbr_q, mbr_d;
  logic [DATA_WIDTH-1:0] ac_q, ac_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]            alu_sel_q, alu_sel_d;
  logic                  illegal_q, illegal_d;

  opcode_e               opcode;
  logic [ADDR_WIDTH-1:0] operand;
  logic                  skip_c;
  logic                  busy_c;

  assign opcode  = opcode_e'(ir_q[DATA_WIDTH-1 -: 4]);
  assign operand = ir_q[ADDR_WIDTH-1:0];
  assign busy_c  = !(state_q inside {S_IDLE, S_HALTED});

  // SKIPCOND condition. AC is treated as two's complement, so "negative"
  // is the sign bit and "positive" is a clear sign bit with a nonzero value.
  always_comb begin
    skip_c = 1'b0;
    unique case (ir_q[ADDR_WIDTH-1 -: 2])
      2'b00:   skip_c = ac_q[DATA_WIDTH-1];
      2'b01:   skip_c = (ac_q == '0);
      2'b10:   skip_c = !ac_q[DATA_WIDTH-1] && (ac_q != '0);
      default: skip_c = 1'b0;
    endcase
  end

  // Memory and ALU controls are registered. A value assigned in state X is
  // seen by the RAM or ALU during the cycle after X. This is why STORE
  // raises we in E2 and the write lands at the end of E3.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mbr_d     = mbr_q;
    ac_d      = ac_q;
    addr_d    = addr_q;
    cs_d      = cs_q;
    we_d      = we_q;
    oe_d      = oe_q;
    wdata_d   = wdata_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    illegal_d = illegal_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = ADDR_WIDTH'(START_ADDR);
          state_d = S_F1;
        end
      end

      S_F1: begin
        addr_d  = pc_q;
        cs_d    = 1'b1;
        oe_d    = 1'b1;
        we_d    = 1'b0;
        state_d = S_F2;
      end

      S_F2: state_d = S_F3;

      S_F3: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + ADDR_WIDTH'(1);
        cs_d    = 1'b0;
        state_d = S_DEC;
      end

      S_DEC: state_d = S_E1;

      S_E1: begin
        state_d = S_F1;
        unique case (opcode)
          OP_LOAD, OP_ADD, OP_SUBT: begin
            addr_d  = operand;
            cs_d    = 1'b1;
            oe_d    = 1'b1;
            state_d = S_E2;
          end
          OP_STORE: begin
            addr_d  = operand;
            cs_d    = 1'b1;
            mbr_d   = ac_q;
            state_d = S_E2;
          end
          OP_HALT:  state_d = S_HALTED;
          OP_SKIP:  if (skip_c) pc_d = pc_q + ADDR_WIDTH'(1);
          OP_JUMP:  pc_d = operand;
          OP_CLEAR: ac_d = '0;
          default:  illegal_d = 1'b1;
        endcase
      end

      S_E2: begin
        if (opcode == OP_STORE) begin
          oe_d    = 1'b0;
          we_d    = 1'b1;
          wdata_d = mbr_q;
        end
        state_d = S_E3;
      end

      S_E3: begin
        cs_d = 1'b0;
        if (opcode == OP_STORE) begin
          we_d    = 1'b0;
          oe_d    = 1'b1;
          state_d = S_F1;
        end else begin
          mbr_d   = mem_rdata;
          state_d = S_E4;
        end
      end

      S_E4: begin
        if (opcode == OP_LOAD) begin
          ac_d    = mbr_q;
          state_d = S_F1;
        end else begin
          alu_a_d   = ac_q;
          alu_b_d   = mbr_q;
          alu_sel_d = (opcode == OP_SUBT) ? 2'b10 : 2'b01;
          state_d   = S_E5;
        end
      end

      S_E5: begin
        ac_d      = alu_out;
        alu_sel_d = 2'b00;
        state_d   = S_F1;
      end

      S_HALTED: state_d = S_HALTED;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      mbr_q     <= '0;
      ac_q      <= '0;
      addr_q    <= '0;
      cs_q      <= 1'b0;
      we_q      <= 1'b0;
      oe_q      <= 1'b1;
      wdata_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= 2'b00;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mbr_q     <= mbr_d;
      ac_q      <= ac_d;
      addr_q    <= addr_d;
      cs_q      <= cs_d;
      we_q      <= we_d;
      oe_q      <= oe_d;
      wdata_q   <= wdata_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      illegal_q <= illegal_d;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_cs     = cs_q;
  assign mem_we     = we_q;
  assign mem_oe     = oe_q;
  assign mem_wdata  = wdata_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign pc         = pc_q;
  assign ac         = ac_q;
  assign ir         = ir_q;
  assign busy       = busy_c;
  assign halted     = (state_q == S_HALTED);
  assign illegal_op = illegal_q;

`ifdef ACC_CPU_PERF_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] instr_cnt_q;
  logic        instr_done;

  // An instruction completes when execute hands back to F1, or when HALT
  // enters HALTED.
  assign instr_done = ((state_d == S_F1) && (state_q inside {S_E1, S_E2, S_E3, S_E4, S_E5}))
                   || ((state_d == S_HALTED) && (state_q != S_HALTED));

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (busy_c && (cycle_cnt_q != '1)) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (instr_done && (instr_cnt_q != '1)) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_acc_cpu_controller.sv
// Testbench for acc_cpu_controller.
// - The RAM model is synchronous and loads its contents from an image array.
// - The ALU model is combinational.
// - The reference model is an instruction-level interpreter of the
//   accumulator ISA.
module tb_acc_cpu_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] mem_addr;
  logic        mem_cs, mem_we, mem_oe;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [1:0]  alu_sel;
  logic [11:0] pc;
  logic [15:0] ac, ir;
  logic        busy, halted, illegal_op;
`ifdef ACC_CPU_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  acc_cpu_controller #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(16),
    .START_ADDR('h100)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .pc(pc), .ac(ac), .ir(ir), .busy(busy), .halted(halted), .illegal_op(illegal_op)
`ifdef ACC_CPU_PERF_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign alu_out = (alu_sel == 2'b01) ? alu_a + alu_b :
                   (alu_sel == 2'b10) ? alu_a - alu_b : 16'h0;

  logic [15:0] ram [0:4095];
  logic [15:0] img [0:4095];
  logic [15:0] mm  [0:4095];
  logic        ram_load = 1'b0;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 4096; i++) ram[i] <= img[i];
    end else if (mem_cs) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else if (mem_oe) mem_rdata <= ram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [15:0] m_ac;
  logic [11:0] m_pc;
  logic        m_ill;
  int unsigned m_instr, m_cyc;

  int illegal_ops [8] = '{0, 5, 6, 11, 12, 13, 14, 15};

  task automatic clear_img();
    for (int i = 0; i < 4096; i++) img[i] = 16'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; ram_load = 1'b1;
    @(negedge clk);
    ram_load = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (halted) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Executes the image from 0x100 one instruction at a time until HALT.
  // The cycle count covers every busy cycle: 4 for fetch/decode plus the
  // execute length of each instruction.
  task automatic model_run();
    logic [15:0] ins;
    logic [3:0]  op;
    logic [11:0] opd;
    int          v;
    bit          done, sk;
    for (int i = 0; i < 4096; i++) mm[i] = img[i];
    m_pc = 12'h100; m_ac = 16'h0; m_ill = 1'b0; m_instr = 0; m_cyc = 0;
    done = 1'b0;
    for (int s = 0; s < 4000 && !done; s++) begin
      ins = mm[m_pc];
      m_pc = m_pc + 12'd1;
      op = ins[15:12];
      opd = ins[11:0];
      m_instr++;
      v = int'($signed(m_ac));
      case (op)
        4'h1: begin m_ac = mm[opd]; m_cyc += 8; end
        4'h2: begin mm[opd] = m_ac; m_cyc += 7; end
        4'h3: begin m_ac = m_ac + mm[opd]; m_cyc += 9; end
        4'h4: begin m_ac = m_ac - mm[opd]; m_cyc += 9; end
        4'h7: begin done = 1'b1; m_cyc += 5; end
        4'h8: begin
          case (opd[11:10])
            2'b00:   sk = (v < 0);
            2'b01:   sk = (v == 0);
            2'b10:   sk = (v > 0);
            default: sk = 1'b0;
          endcase
          if (sk) m_pc = m_pc + 12'd1;
          m_cyc += 5;
        end
        4'h9: begin m_pc = opd; m_cyc += 5; end
        4'hA: begin m_ac = 16'h0; m_cyc += 5; end
        default: begin m_ill = 1'b1; m_cyc += 5; end
      endcase
    end
  endtask

  function automatic int first_diff();
    for (int i = 0; i < 4096; i++) if (ram[i] !== mm[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    clear_img();
    do_reset();
    n_checks++;
    if ({mem_cs, mem_we, mem_oe, busy, halted, illegal_op} !== 6'b001000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got cs/we/oe/busy/halted/ill=%b required 001000",
               {mem_cs, mem_we, mem_oe, busy, halted, illegal_op});
    end
    n_checks++;
    if ({mem_addr, pc, ac, ir, mem_wdata, alu_a, alu_b, alu_sel} !== 106'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h pc=%h ac=%h ir=%h wd=%h a=%h b=%h sel=%b required all zero",
               mem_addr, pc, ac, ir, mem_wdata, alu_a, alu_b, alu_sel);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || pc !== 12'h0) begin
      n_fail++;
      $display("FAIL idle_hold: busy=%b pc=%h required busy=0 pc=000", busy, pc);
    end
  endtask

  task automatic test_multiply();
    bit ok;
    int d;
    logic [15:0] prog [16] = '{16'h110C, 16'h210E, 16'h110D, 16'h310B, 16'h210D, 16'h110E,
                              16'h310F, 16'h210E, 16'h8400, 16'h9102, 16'h7000, 16'h0005,
                              16'h0007, 16'h0000, 16'h0000, 16'hFFFF};
    clear_img();
    for (int i = 0; i < 16; i++) img[12'h100 + i] = prog[i];
    do_reset();
    model_run();
    pulse_start();
    wait_halt(3000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mul_halt: halted=%b required 1 within bound", halted); end
    n_checks++;
    if (ram[12'h10D] !== 16'h0023) begin
      n_fail++; $display("FAIL mul_product: got %h required 0023", ram[12'h10D]);
    end
    n_checks++;
    if (ram[12'h10E] !== 16'h0000) begin
      n_fail++; $display("FAIL mul_counter: got %h required 0000", ram[12'h10E]);
    end
    n_checks++;
    if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL mul_illegal: got %b required 0", illegal_op); end
    n_checks++;
    if (ac !== m_ac || pc !== m_pc) begin
      n_fail++; $display("FAIL mul_regs: ac=%h pc=%h required ac=%h pc=%h", ac, pc, m_ac, m_pc);
    end
    d = first_diff();
    n_checks++;
    if (d != -1) begin n_fail++; $display("FAIL mul_mem: addr %h got %h required %h", d, ram[d], mm[d]); end
`ifdef ACC_CPU_PERF_EN
    n_checks++;
    if (instr_cnt !== m_instr || cycle_cnt !== m_cyc) begin
      n_fail++;
      $display("FAIL mul_perf: instr=%0d cyc=%0d required instr=%0d cyc=%0d", instr_cnt, cycle_cnt, m_instr, m_cyc);
    end
`endif
  endtask

  task automatic test_load_timing();
    clear_img();
    img[12'h100] = 16'h1105; img[12'h101] = 16'h7000; img[12'h105] = 16'h1234;
    do_reset();
    pulse_start();
    repeat (7) @(negedge clk);
    n_checks++;
    if (ac !== 16'h0000) begin n_fail++; $display("FAIL load_early: ac=%h required 0000 after 7 cycles", ac); end
    @(negedge clk);
    n_checks++;
    if (ac !== 16'h1234) begin n_fail++; $display("FAIL load_ac: ac=%h required 1234 after 8 cycles", ac); end
    n_checks++;
    if (pc !== 12'h101) begin n_fail++; $display("FAIL load_pc: pc=%h required 101", pc); end
  endtask

  task automatic test_skipcond();
    bit ok;
    logic [15:0] vals [6];
    logic [11:0] exp_pc;
    bit          match;
    vals[0] = 16'hFFFF; vals[1] = 16'h0000; vals[2] = 16'h0001;
    for (int i = 3; i < 6; i++) vals[i] = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 6; i++) begin
      for (int c = 0; c < 4; c++) begin
        clear_img();
        img[12'h100] = 16'h11F0;
        img[12'h101] = 16'h8000 | 16'(c << 10);
        img[12'h102] = 16'h7000;
        img[12'h103] = 16'h7000;
        img[12'h1F0] = vals[i];
        do_reset();
        model_run();
        pulse_start();
        wait_halt(200, ok);
        if (i < 3) begin
          match = (i == c) && (c != 3);
          exp_pc = match ? 12'h104 : 12'h103;
        end else begin
          exp_pc = m_pc;
        end
        n_checks++;
        if (!ok || pc !== exp_pc) begin
          n_fail++;
          $display("FAIL skip_ac%h_c%0d: pc=%h halted=%b required pc=%h", vals[i], c, pc, halted, exp_pc);
        end
      end
    end
  endtask

  task automatic test_store();
    int we_cycles = 0;
    int oe_bad = 0;
    logic [11:0] w_addr = 12'h0;
    logic [15:0] w_data = 16'h0;
    logic        w_oe = 1'b1;
    clear_img();
    img[12'h100] = 16'h11F0; img[12'h101] = 16'h2120; img[12'h102] = 16'h7000;
    img[12'h1F0] = 16'hBEEF;
    do_reset();
    pulse_start();
    for (int i = 0; i < 200 && !halted; i++) begin
      if (mem_we) begin
        we_cycles++; w_addr = mem_addr; w_data = mem_wdata; w_oe = mem_oe;
      end
      if (!mem_oe && !mem_we) oe_bad++;
      @(negedge clk);
    end
    n_checks++;
    if (we_cycles != 1) begin n_fail++; $display("FAIL store_we_len: %0d cycles required 1", we_cycles); end
    n_checks++;
    if (w_addr !== 12'h120 || w_data !== 16'hBEEF || w_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL store_bus: addr=%h data=%h oe=%b required 120 BEEF 0", w_addr, w_data, w_oe);
    end
    n_checks++;
    if (oe_bad != 0) begin n_fail++; $display("FAIL store_oe: oe low without we %0d cycles required 0", oe_bad); end
    n_checks++;
    if (ram[12'h120] !== 16'hBEEF) begin n_fail++; $display("FAIL store_ram: got %h required BEEF", ram[12'h120]); end
  endtask

  task automatic test_illegal();
    bit ok;
    logic [15:0] v;
    int k;
    v = 16'($urandom_range(1, 65535));
    k = $urandom_range(0, 7);
    clear_img();
    img[12'h100] = 16'h11F0; img[12'h101] = 16'hF000;
    img[12'h102] = 16'(illegal_ops[k] << 12) | 16'($urandom_range(0, 4095));
    img[12'h103] = 16'h7000; img[12'h1F0] = v;
    do_reset();
    pulse_start();
    wait_halt(200, ok);
    n_checks++;
    if (!ok || illegal_op !== 1'b1) begin
      n_fail++; $display("FAIL illegal_flag: halted=%b illegal=%b required 1 1", halted, illegal_op);
    end
    n_checks++;
    if (ac !== v) begin n_fail++; $display("FAIL illegal_ac: ac=%h required %h", ac, v); end
    pulse_start();
    repeat (3) @(negedge clk);
    n_checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || illegal_op !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_hold: halted=%b busy=%b illegal=%b required 1 0 1", halted, busy, illegal_op);
    end
  endtask

  task automatic test_reset_mid_store();
    bit ok, seen;
    logic [15:0] v;
    v = 16'($urandom_range(0, 65535)) ^ 16'h5A5A;
    if (v == 16'h5A5A) v = 16'h1111;
    clear_img();
    img[12'h100] = 16'h11F0; img[12'h101] = 16'h2120; img[12'h102] = 16'h7000;
    img[12'h1F0] = v; img[12'h120] = 16'h5A5A;
    do_reset();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_cs && mem_addr == 12'h120) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rst_store_reach: store address not seen, required within 50 cycles"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({mem_we, mem_oe, busy, halted} !== 4'b0100 || pc !== 12'h0) begin
      n_fail++;
      $display("FAIL rst_store_state: we/oe/busy/halted=%b pc=%h required 0100 000",
               {mem_we, mem_oe, busy, halted}, pc);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (ram[12'h120] !== 16'h5A5A) begin
      n_fail++; $display("FAIL rst_store_nowrite: ram=%h required 5A5A", ram[12'h120]);
    end
    pulse_start();
    @(negedge clk);
    n_checks++;
    if (mem_addr !== 12'h100 || mem_cs !== 1'b1) begin
      n_fail++; $display("FAIL rst_refetch: addr=%h cs=%b required 100 1", mem_addr, mem_cs);
    end
    wait_halt(200, ok);
    n_checks++;
    if (!ok || ram[12'h120] !== v) begin
      n_fail++; $display("FAIL rst_rerun: halted=%b ram=%h required 1 %h", halted, ram[12'h120], v);
    end
  endtask

  task automatic test_random_programs();
    bit ok;
    int d, k;
    logic [11:0] a;
    for (int r = 0; r < 8; r++) begin
      clear_img();
      for (int i = 0; i < 16; i++) img[12'h180 + i] = 16'($urandom_range(0, 65535));
      for (int i = 0; i < 10; i++) begin
        a = 12'h180 + 12'($urandom_range(0, 15));
        k = $urandom_range(0, 7);
        case (k)
          0: img[12'h100 + i] = {4'h1, a};
          1: img[12'h100 + i] = {4'h2, a};
          2: img[12'h100 + i] = {4'h3, a};
          3: img[12'h100 + i] = {4'h4, a};
          4: img[12'h100 + i] = {4'h8, 2'($urandom_range(0, 3)), 10'h0};
          5: img[12'h100 + i] = 16'hA000;
          6: img[12'h100 + i] = {4'h9, 12'(12'h101 + i + $urandom_range(0, 2))};
          default: img[12'h100 + i] = 16'(illegal_ops[$urandom_range(0, 7)] << 12);
        endcase
      end
      img[12'h10A] = 16'h7000; img[12'h10B] = 16'h7000; img[12'h10C] = 16'h7000;
      do_reset();
      model_run();
      pulse_start();
      wait_halt(1000, ok);
      n_checks++;
      if (!ok || ac !== m_ac || pc !== m_pc || illegal_op !== m_ill) begin
        n_fail++;
        $display("FAIL rand%0d_regs: halted=%b ac=%h pc=%h ill=%b required ac=%h pc=%h ill=%b",
                 r, halted, ac, pc, illegal_op, m_ac, m_pc, m_ill);
      end
      d = first_diff();
      n_checks++;
      if (d != -1) begin n_fail++; $display("FAIL rand%0d_mem: addr %h got %h required %h", r, d, ram[d], mm[d]); end
`ifdef ACC_CPU_PERF_EN
      n_checks++;
      if (instr_cnt !== m_instr || cycle_cnt !== m_cyc) begin
        n_fail++;
        $display("FAIL rand%0d_perf: instr=%0d cyc=%0d required instr=%0d cyc=%0d",
                 r, instr_cnt, cycle_cnt, m_instr, m_cyc);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_load_timing();
    test_skipcond();
    test_store();
    test_illegal();
    test_reset_mid_store();
    test_random_programs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_cpu_controller.md
Name: acc_cpu_controller

Overview:
- Hardware fetch/decode/execute sequencer for the 16-bit accumulator CPU.
- Owns PC, IR, MBR and AC, and drives the synchronous single-port RAM (cs/we/oe, shared data path) and the combinational ALU.
- Replaces bench-driven sequencing; integrates between RAM, ALU and top-level start/halt control.

Parameters:
- ADDR_WIDTH, 12, RAM word-address width; IR[11:0] operand field.
- DATA_WIDTH, 16, word width of RAM data, IR, MBR, AC, ALU operands.
- START_ADDR, 'h100, PC value loaded on start.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  in IDLE: load PC=START_ADDR, begin fetching.
- mem_addr  output  ADDR_WIDTH  RAM address (registered).
- mem_cs  output  1  RAM chip select.
- mem_we  output  1  RAM write enable.
- mem_oe  output  1  RAM output enable (1=RAM drives read data).
- mem_wdata  output  DATA_WIDTH  write data; top tristates the bus with !oe.
- mem_rdata  input  DATA_WIDTH  RAM read data; valid the cycle after the address is registered with cs=1, oe=1.
- alu_a  output  DATA_WIDTH  ALU operand A (registered).
- alu_b  output  DATA_WIDTH  ALU operand B (registered).
- alu_sel  output  2  01=add, 10=sub, 00=idle.
- alu_out  input  DATA_WIDTH  combinational ALU result.
- pc, ac, ir  output  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH  architectural state, for debug.
- busy  output  1  high in any state except IDLE and HALTED.
- halted  output  1  high in HALTED.
- illegal_op  output  1  sticky; set on undefined opcode.

Behaviour:
- Reset (sync, priority over all):
  - State=IDLE.
  - PC, IR, MBR, AC, mem_addr, mem_wdata, alu_a, alu_b = 0.
  - mem_cs=0, mem_we=0, mem_oe=1, alu_sel=00, illegal_op=0.
  - Reset mid-instruction abandons it; a pending write (we=1) is deasserted on the reset edge.
- IDLE:
  - start=1 -> PC<=START_ADDR, go to F1. Otherwise hold.
- Fetch, every instruction:
  - F1: mem_addr<=PC; cs=1, oe=1, we=0.
  - F2: wait.
  - F3: IR<=mem_rdata; PC<=PC+1 (wraps mod 2^ADDR_WIDTH).
  - DEC: dispatch on IR[15:12].
  - Fetch+decode = 4 cycles.
- Execute, cycles after DEC:
  - 1 LOAD (4): E1 mem_addr<=IR[11:0], oe=1; E2 wait; E3 MBR<=rdata; E4 AC<=MBR.
  - 2 STORE (3): E1 mem_addr<=IR[11:0], MBR<=AC; E2 oe=0, we=1, mem_wdata<=MBR; E3 we=0, oe=1. Exactly one write cycle.
  - 3 ADD / 4 SUBT (5): E1-E3 as LOAD; E4 alu_a<=AC, alu_b<=MBR, alu_sel<=01 or 10; E5 AC<=alu_out, alu_sel<=00. Result wraps mod 2^DATA_WIDTH; no overflow flag.
  - 7 HALT (1): go to HALTED. Stay until rst; start is ignored there.
  - 8 SKIPCOND (1): AC compared as signed. Skip (PC<=PC+1) if:
    - IR[11:10]=00 and AC<0;
    - IR[11:10]=01 and AC==0;
    - IR[11:10]=10 and AC>0.
    - IR[11:10]=11 never skips.
  - 9 JUMP (1): PC<=IR[11:0].
  - A CLEAR (1): AC<=0.
  - Any other opcode (1): no architectural change; illegal_op<=1; continue.
- After every execute sequence, return to F1.
- RAM is never written outside STORE E2.
- mem_oe=0 only while mem_we=1.

Optional Feature:
- Macro ACC_CPU_PERF_EN.
- Defined:
  - Extra output ports cycle_cnt[31:0] and instr_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle with busy=1.
  - instr_cnt increments on each return to F1 from execute, and on entry to HALTED.
  - Both saturate at 'hFFFFFFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Multiply program (RAM 'h100-'h10F: 110C 210E 110D 310B 210D 110E 310F 210E 8400 9102 7000 0005 0007 0000 0000 FFFF), start -> halted=1; RAM['h10D]=0x0023, RAM['h10E]=0x0000; illegal_op=0.
- Single LOAD 'h1105 with RAM['h105]=0x1234 -> ac=0x1234 exactly 8 cycles after F1 entry; pc=START_ADDR+1.
- SKIPCOND sweep with AC=0xFFFF, 0x0000, 0x0001 against IR[11:10]=00/01/10/11 -> pc advances by 2 only on matching pairs (00/0xFFFF, 01/0x0000, 10/0x0001), else by 1.
- STORE 'h2120 with AC=0xBEEF -> mem_we high for exactly one cycle, mem_addr='h120, mem_wdata=0xBEEF, mem_oe=0 in that cycle; RAM['h120]=0xBEEF.
- Opcode 0xF000 then HALT -> illegal_op=1 stays set; halted=1; AC unchanged.
- rst asserted at STORE E2 -> next cycle mem_we=0, mem_oe=1, pc=0, state IDLE, busy=0; subsequent start refetches from 'h100.
